// File: rtl/regset_writeback_pkg.sv
// Shared core definitions for the register-set write-back stage: address/data
// widths, the zero register, the write-port selection and the output register layout.
package regset_writeback_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_LOAD
  } wb_sel_e;

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_out_t;

endpackage

// File: rtl/regset_wb_tagfifo.sv
// Tag FIFO of outstanding load destinations, with an "any entry equals r" match
// that tells the write-back stage whether a register must stay busy.
module regset_wb_tagfifo
  import regset_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [REG_AW-1:0] push_rd_i,
  input  logic              pop_i,
  input  logic [REG_AW-1:0] match_rd_i,
  output logic [REG_AW-1:0] head_rd_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              match_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_AW-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign head_rd_o = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem_q[i] == match_rd_i)) match_o = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the tag storage is not reset; valid_q and count_q qualify every use of it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_rd_i;
  end

endmodule

// File: rtl/regset_writeback.sv
// Write-back stage: merges ALU results and in-order load responses onto the single
// register-set write port and tracks per-register busy bits for outstanding loads.
module regset_writeback
  import regset_writeback_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_issue,
  input  logic [REG_AW-1:0]   ld_rd,
  output logic                ld_issue_ready,
  input  logic                ld_rsp_valid,
  input  logic [DATA_W-1:0]   ld_rsp_data,
  output logic                ld_rsp_ready,
  output logic [DATA_W-1:0]   wb_D,
  output logic [REG_AW-1:0]   wb_A_D,
  output logic                wb_write_enable,
  output logic [NUM_REGS-1:0] busy
);

  wb_sel_e             sel;
  wb_out_t             wb_q, wb_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_AW-1:0]   head_rd;
  logic                fifo_full, fifo_empty, fifo_match;
  logic                issue_ok, rsp_ok, load_pop, busy_clear;

  regset_wb_tagfifo #(
    .DEPTH(LD_DEPTH)
  ) u_tagfifo (
    .clk       (CLK),
    .rst_n     (RES),
    .push_i    (ld_issue),
    .push_rd_i (ld_rd),
    .pop_i     (load_pop),
    .match_rd_i(wb_q.addr),
    .head_rd_o (head_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .match_o   (fifo_match)
  );

  assign ld_issue_ready = !fifo_full;
  assign issue_ok       = ld_issue && !fifo_full;

  always_comb begin
    sel = SEL_NONE;
    if (alu_valid && (alu_rd != ZERO_REG)) sel = SEL_ALU;
    else if (pend_valid_q)                 sel = SEL_LOAD;
  end

  assign load_pop     = (sel == SEL_LOAD);
  assign ld_rsp_ready = !pend_valid_q || load_pop;
  // A response with no outstanding tag is a protocol error and is dropped.
  assign rsp_ok       = ld_rsp_valid && ld_rsp_ready && !fifo_empty;

  // The register set captures the load at this edge; keep busy if a younger load targets r.
  assign busy_clear = wb_q.we && wb_q.is_load && !fifo_match;

  always_comb begin
    wb_d         = wb_q;
    wb_d.we      = 1'b0;
    wb_d.is_load = 1'b0;
    unique case (sel)
      SEL_ALU: begin
        wb_d.we   = 1'b1;
        wb_d.addr = alu_rd;
        wb_d.data = alu_data;
      end
      SEL_LOAD: begin
        wb_d.we      = (head_rd != ZERO_REG);
        wb_d.is_load = 1'b1;
        wb_d.addr    = head_rd;
        wb_d.data    = pend_data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    if (load_pop) pend_valid_d = 1'b0;
    if (rsp_ok) begin
      pend_valid_d = 1'b1;
      pend_data_d  = ld_rsp_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (busy_clear) busy_d[wb_q.addr] = 1'b0;
    if (issue_ok)   busy_d[ld_rd]     = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      wb_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      busy_q       <= '0;
    end else begin
      wb_q         <= wb_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      busy_q       <= busy_d;
    end
  end

  assign wb_D            = wb_q.data;
  assign wb_A_D          = wb_q.addr;
  assign wb_write_enable = wb_q.we;
  assign busy            = busy_q;

  a_rsp_has_tag: assert property (@(posedge CLK) disable iff (!RES)
    !(ld_rsp_valid && ld_rsp_ready && fifo_empty));

  a_alu_not_busy: assert property (@(posedge CLK) disable iff (!RES)
    !(alu_valid && (alu_rd != ZERO_REG) && busy_q[alu_rd]));

endmodule

// File: tb/tb_regset_writeback.sv
// Directed bench for regset_writeback: ALU path, load path, port contention,
// FIFO full / duplicate destinations, x0 loads with pointer wrap, mid-run reset.
module tb_regset_writeback;

  logic        CLK;
  logic        RES;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_issue_ready;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        ld_rsp_ready;
  logic [31:0] wb_D;
  logic [4:0]  wb_A_D;
  logic        wb_write_enable;
  logic [31:0] busy;

  int checks;
  int failures;

  regset_writeback #(.LD_DEPTH(4)) dut (
    .CLK            (CLK),
    .RES            (RES),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_rd          (ld_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_rsp_valid   (ld_rsp_valid),
    .ld_rsp_data    (ld_rsp_data),
    .ld_rsp_ready   (ld_rsp_ready),
    .wb_D           (wb_D),
    .wb_A_D         (wb_A_D),
    .wb_write_enable(wb_write_enable),
    .busy           (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++; if (wb_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", wb_write_enable); end
    checks++; if (wb_D !== 32'h0) begin failures++; $display("FAIL rst_wb_D got=%h exp=0", wb_D); end
    checks++; if (wb_A_D !== 5'd0) begin failures++; $display("FAIL rst_wb_A_D got=%0d exp=0", wb_A_D); end
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy); end
    checks++; if (ld_rsp_ready !== 1'b1) begin failures++; $display("FAIL rst_rsp_ready got=%0h exp=1", ld_rsp_ready); end
    checks++; if (ld_issue_ready !== 1'b1) begin failures++; $display("FAIL rst_issue_ready got=%0h exp=1", ld_issue_ready); end
    RES = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_rd = 5'd0; alu_data = 32'h0BADF00D;
    checks++; if (wb_write_enable !== 1'b1) begin failures++; $display("FAIL alu_we got=%0h exp=1", wb_write_enable); end
    checks++; if (wb_A_D !== 5'd5) begin failures++; $display("FAIL alu_addr got=%0d exp=5", wb_A_D); end
    checks++; if (wb_D !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got=%h exp=deadbeef", wb_D); end
    step();
    alu_valid = 1'b0;
    checks++; if (wb_write_enable !== 1'b0) begin failures++; $display("FAIL alu_x0_we got=%0h exp=0", wb_write_enable); end
    checks++; if (wb_D !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_x0_hold got=%h exp=deadbeef", wb_D); end
    step();
  endtask

  task automatic test_load_basic();
    ld_issue = 1'b1; ld_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    checks++; if (busy !== 32'h80) begin failures++; $display("FAIL ld_busy_set got=%h exp=80", busy); end
    step();
    step();
    checks++; if (busy !== 32'h80) begin failures++; $display("FAIL ld_busy_hold got=%h exp=80", busy); end
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h12345678;
    #1;
    checks++; if (ld_rsp_ready !== 1'b1) begin failures++; $display("FAIL ld_rsp_ready got=%0h exp=1", ld_rsp_ready); end
    step();
    ld_rsp_valid = 1'b0;
    checks++; if (wb_write_enable !== 1'b0) begin failures++; $display("FAIL ld_pend_we got=%0h exp=0", wb_write_enable); end
    step();
    checks++; if (wb_write_enable !== 1'b1) begin failures++; $display("FAIL ld_we got=%0h exp=1", wb_write_enable); end
    checks++; if (wb_A_D !== 5'd7) begin failures++; $display("FAIL ld_addr got=%0d exp=7", wb_A_D); end
    checks++; if (wb_D !== 32'h12345678) begin failures++; $display("FAIL ld_data got=%h exp=12345678", wb_D); end
    checks++; if (busy !== 32'h80) begin failures++; $display("FAIL ld_busy_write got=%h exp=80", busy); end
    step();
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL ld_busy_clear got=%h exp=0", busy); end
    checks++; if (wb_write_enable !== 1'b0) begin failures++; $display("FAIL ld_idle_we got=%0h exp=0", wb_write_enable); end
  endtask

  task automatic test_alu_vs_load();
    ld_issue = 1'b1; ld_rd = 5'd9;
    step();
    ld_rd = 5'd10;
    step();
    ld_issue = 1'b0;
    checks++; if (busy !== 32'h600) begin failures++; $display("FAIL mix_busy got=%h exp=600", busy); end
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA0003;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h11110009;
    step();
    alu_rd = 5'd4; alu_data = 32'hAAAA0004; ld_rsp_data = 32'h2222000A;
    #1;
    checks++; if (ld_rsp_ready !== 1'b0) begin failures++; $display("FAIL mix_rsp_blocked got=%0h exp=0", ld_rsp_ready); end
    checks++; if (wb_A_D !== 5'd3 || wb_D !== 32'hAAAA0003 || wb_write_enable !== 1'b1)
      begin failures++; $display("FAIL mix_alu1 got=%0d/%h/%0h exp=3/aaaa0003/1", wb_A_D, wb_D, wb_write_enable); end
    step();
    alu_valid = 1'b0;
    #1;
    checks++; if (ld_rsp_ready !== 1'b1) begin failures++; $display("FAIL mix_rsp_drain got=%0h exp=1", ld_rsp_ready); end
    checks++; if (wb_A_D !== 5'd4 || wb_D !== 32'hAAAA0004 || wb_write_enable !== 1'b1)
      begin failures++; $display("FAIL mix_alu2 got=%0d/%h/%0h exp=4/aaaa0004/1", wb_A_D, wb_D, wb_write_enable); end
    step();
    ld_rsp_valid = 1'b0;
    checks++; if (wb_A_D !== 5'd9 || wb_D !== 32'h11110009 || wb_write_enable !== 1'b1)
      begin failures++; $display("FAIL mix_ld1 got=%0d/%h/%0h exp=9/11110009/1", wb_A_D, wb_D, wb_write_enable); end
    checks++; if (busy !== 32'h600) begin failures++; $display("FAIL mix_busy_ld1 got=%h exp=600", busy); end
    step();
    checks++; if (wb_A_D !== 5'd10 || wb_D !== 32'h2222000A || wb_write_enable !== 1'b1)
      begin failures++; $display("FAIL mix_ld2 got=%0d/%h/%0h exp=10/2222000a/1", wb_A_D, wb_D, wb_write_enable); end
    checks++; if (busy !== 32'h400) begin failures++; $display("FAIL mix_busy_ld2 got=%h exp=400", busy); end
    step();
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL mix_busy_end got=%h exp=0", busy); end
  endtask

  task automatic test_full();
    ld_issue = 1'b1; ld_rd = 5'd1;
    step();
    ld_rd = 5'd2;
    step();
    step();
    ld_rd = 5'd3;
    step();
    ld_rd = 5'd5;
    #1;
    checks++; if (ld_issue_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", ld_issue_ready); end
    checks++; if (busy !== 32'hE) begin failures++; $display("FAIL full_busy got=%h exp=e", busy); end
    step();
    ld_issue = 1'b0;
    checks++; if (busy !== 32'hE) begin failures++; $display("FAIL full_reject got=%h exp=e", busy); end
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h101;
    step();
    ld_rsp_data = 32'h102;
    step();
    ld_rsp_data = 32'h103;
    checks++; if (ld_issue_ready !== 1'b1) begin failures++; $display("FAIL full_ready_again got=%0h exp=1", ld_issue_ready); end
    checks++; if (wb_A_D !== 5'd1 || wb_D !== 32'h101 || wb_write_enable !== 1'b1)
      begin failures++; $display("FAIL full_wr1 got=%0d/%h/%0h exp=1/101/1", wb_A_D, wb_D, wb_write_enable); end
    step();
    ld_rsp_data = 32'h104;
    checks++; if (wb_A_D !== 5'd2 || wb_D !== 32'h102) begin failures++; $display("FAIL full_wr2a got=%0d/%h exp=2/102", wb_A_D, wb_D); end
    checks++; if (busy !== 32'hC) begin failures++; $display("FAIL full_busy_a got=%h exp=c", busy); end
    step();
    ld_rsp_valid = 1'b0;
    checks++; if (wb_A_D !== 5'd2 || wb_D !== 32'h103) begin failures++; $display("FAIL full_wr2b got=%0d/%h exp=2/103", wb_A_D, wb_D); end
    checks++; if (busy !== 32'hC) begin failures++; $display("FAIL full_busy2_held got=%h exp=c", busy); end
    step();
    checks++; if (wb_A_D !== 5'd3 || wb_D !== 32'h104) begin failures++; $display("FAIL full_wr3 got=%0d/%h exp=3/104", wb_A_D, wb_D); end
    checks++; if (busy !== 32'h8) begin failures++; $display("FAIL full_busy2_clear got=%h exp=8", busy); end
    step();
    checks++; if (busy !== 32'h0 || wb_write_enable !== 1'b0) begin failures++; $display("FAIL full_end got=%h/%0h exp=0/0", busy, wb_write_enable); end
  endtask

  task automatic test_x0_wrap();
    logic [31:0] d0, d4;
    for (int k = 0; k < 5; k++) begin
      d0 = 32'hA0000000 + 32'(k);
      d4 = 32'hB0000000 + 32'(k);
      ld_issue = 1'b1; ld_rd = 5'd0;
      step();
      ld_rd = 5'd4;
      step();
      ld_issue = 1'b0;
      checks++; if (busy !== 32'h10) begin failures++; $display("FAIL x0_busy it=%0d got=%h exp=10", k, busy); end
      ld_rsp_valid = 1'b1; ld_rsp_data = d0;
      step();
      ld_rsp_data = d4;
      step();
      ld_rsp_valid = 1'b0;
      checks++; if (wb_write_enable !== 1'b0) begin failures++; $display("FAIL x0_nowrite it=%0d got=%0h exp=0", k, wb_write_enable); end
      step();
      checks++; if (wb_write_enable !== 1'b1 || wb_A_D !== 5'd4 || wb_D !== d4)
        begin failures++; $display("FAIL x4_write it=%0d got=%0h/%0d/%h exp=1/4/%h", k, wb_write_enable, wb_A_D, wb_D, d4); end
      step();
      checks++; if (busy !== 32'h0) begin failures++; $display("FAIL x4_busy_clear it=%0d got=%h exp=0", k, busy); end
    end
  endtask

  task automatic test_reset_mid();
    ld_issue = 1'b1; ld_rd = 5'd6;
    step();
    ld_rd = 5'd8;
    step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hC0DE000B;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h55550006;
    step();
    ld_rsp_valid = 1'b0; alu_rd = 5'd12; alu_data = 32'hC0DE000C;
    #1;
    checks++; if (ld_rsp_ready !== 1'b0) begin failures++; $display("FAIL mrst_pend_held got=%0h exp=0", ld_rsp_ready); end
    checks++; if (wb_write_enable !== 1'b1 || busy !== 32'h140)
      begin failures++; $display("FAIL mrst_pre got=%0h/%h exp=1/140", wb_write_enable, busy); end
    #2;
    RES = 1'b0; alu_valid = 1'b0;
    #1;
    checks++; if (wb_write_enable !== 1'b0 || wb_D !== 32'h0 || wb_A_D !== 5'd0)
      begin failures++; $display("FAIL mrst_wb got=%0h/%h/%0d exp=0/0/0", wb_write_enable, wb_D, wb_A_D); end
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL mrst_busy got=%h exp=0", busy); end
    checks++; if (ld_rsp_ready !== 1'b1 || ld_issue_ready !== 1'b1)
      begin failures++; $display("FAIL mrst_ready got=%0h/%0h exp=1/1", ld_rsp_ready, ld_issue_ready); end
    step();
    step();
    RES = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (wb_write_enable !== 1'b0 || busy !== 32'h0)
        begin failures++; $display("FAIL mrst_after c=%0d got=%0h/%h exp=0/0", k, wb_write_enable, busy); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    RES = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_rd = '0;
    ld_rsp_valid = 1'b0; ld_rsp_data = '0;
    #1 RES = 1'b0;
    test_reset();
    test_alu();
    test_load_basic();
    test_alu_vs_load();
    test_full();
    test_x0_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regset_writeback.md
# regset_writeback

Write-back stage feeding the single write port of the core's register set. Merges single-cycle ALU results with variable-latency, in-order load responses. Tracks outstanding load destinations in a tag FIFO and exports a per-register busy mask used by decode for hazard stalls. Output is registered, so a busy bit clears exactly when the register set captures the load data; no forwarding path is needed.

## Interface

- LD_DEPTH, 4, maximum outstanding loads; power of two, 2..16.
- CLK  in  1  clock; all state updates on the rising edge.
- RES  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result present this cycle; cannot be stalled.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_issue  in  1  load issued; accepted only when ld_issue_ready=1.
- ld_rd  in  5  load destination register.
- ld_issue_ready  out  1  tag FIFO not full.
- ld_rsp_valid  in  1  load data returning; responses arrive in issue order.
- ld_rsp_data  in  32  load data.
- ld_rsp_ready  out  1  response accepted this cycle.
- wb_D  out  32  write data to the register set.
- wb_A_D  out  5  write address to the register set.
- wb_write_enable  out  1  write strobe to the register set.
- busy  out  32  bit i=1 while a load to xi is outstanding or unwritten; bit 0 is always 0.

## Operation

- Tag FIFO: LD_DEPTH entries of 5-bit rd. Push on ld_issue && ld_issue_ready. Pop when a load write is selected for output. Read and write pointers wrap modulo LD_DEPTH. Full and empty are tracked with a count of 0..LD_DEPTH.
- Response holding register (pend_valid, pend_data): loads on ld_rsp_valid && ld_rsp_ready.
  - ld_rsp_ready = !pend_valid || pend drained this cycle.
  - A response with an empty tag FIFO is a protocol error: it is dropped and flagged by an assertion.
- Selection each cycle, in priority order:
  1. ALU: alu_valid && alu_rd!=0 → output register loads {alu_data, alu_rd, 1}.
  2. Load: else if pend_valid → output register loads {pend_data, fifo head rd, rd!=0}, then pop and clear pend_valid.
  3. Otherwise wb_write_enable goes to 0. wb_D and wb_A_D hold their values.
- Loads to x0 occupy a FIFO slot and are drained normally. They never set busy and never write.
- Busy tracking:
  - busy[rd] is set at the edge that accepts ld_issue (rd!=0).
  - busy[r] is cleared at the edge after the output register holds a load write to r, but only if no remaining FIFO entry also targets r. That edge is the one at which the register set captures the data.
  - Same-edge set and clear of the same bit: set wins.
- The issuer must stall any instruction whose source or destination has its busy bit set. An ALU write to a busy register is an assertion failure.

## Timing

- ALU result in cycle N → wb_write_enable=1 in cycle N+1 → register set updated at end of N+1.
- Load response accepted in cycle N → written in N+1 at the earliest, or later while ALU writes occupy the port → busy clears at the end of the write cycle.
- ld_issue accepted in cycle N → busy bit visible in N+1.
- When full, ld_issue_ready=0. There is no pass-through of a same-cycle pop.
- Reset (RES low, any time, including mid-transfer): FIFO empty, pend_valid=0, busy=0, wb_write_enable=0, wb_D=0, wb_A_D=0, ld_rsp_ready=1, ld_issue_ready=1. In-flight loads are discarded.

## Structure

- Shared core package: register address width (5), data width (32), and the zero-register constant.
- One sub-module: regset_wb_tagfifo, a parameterised synchronous FIFO with a content-match output "any entry equals r". The match is used for the busy-clear check.

## Test plan

- Reset, then alu_valid with rd=5, data=0xDEADBEEF → next cycle wb_write_enable=1, wb_A_D=5, wb_D=0xDEADBEEF. With rd=0 → no write.
- ld_issue rd=7, response 0x12345678 three cycles later → busy[7]=1 from issue+1 until the write cycle ends. The write appears one cycle after the response.
- ALU valid in the same cycle as a load response → ALU written first, load written next cycle; ld_rsp_ready=0 for a second response held behind the first.
- Four loads issued (rd 1,2,2,3) with LD_DEPTH=4 → ld_issue_ready=0. busy[2] stays 1 after the first rd=2 write and clears only after the second.
- Load to x0 followed by a load to x4 → no write for x0, busy[0]=0 throughout; x4 written, FIFO pointers wrap correctly over 10 issue/drain cycles.
- RES asserted low with two loads outstanding and pend_valid=1 → all outputs return to their reset values immediately; no later write occurs.
